store_wr_buf: RTL

STORE_WR_BUF -- requirements
Module: store_wr_buf

---
 rtl/store_wr_buf_pkg.sv | 25 ++
 rtl/store_wr_buf_ptr.sv | 49 ++++
 rtl/store_wr_buf.sv | 125 ++++++++++++
 3 files changed

// File: rtl/store_wr_buf_pkg.sv
// Shared types for the store write buffer: entry layout, drain FSM encoding,
// default depth and the bit-granular merge helper.
package store_wr_buf_pkg;

  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] mask;
    logic [31:0] dat;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_e;

  function automatic logic [31:0] merge_bits(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] new_mask);
    return (new_v & new_mask) | (old_v & ~new_mask);
  endfunction

endpackage

// File: rtl/store_wr_buf_ptr.sv
// Head/tail pointers and occupancy count for the store write buffer.
// Callers guarantee no allocation when full and no pop when empty.
module store_wr_buf_ptr
  import store_wr_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     i_alloc,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH)-1:0] o_head,
  output logic [$clog2(DEPTH)-1:0] o_tail,
  output logic [$clog2(DEPTH)-1:0] o_youngest,
  output logic [$clog2(DEPTH):0]   o_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (i_alloc) r_tail <= r_tail + PW'(1);
      if (i_pop)   r_head <= r_head + PW'(1);
      unique case ({i_alloc, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head     = r_head;
  assign o_tail     = r_tail;
  assign o_youngest = r_tail - PW'(1);
  assign o_cnt      = r_cnt;

endmodule

// File: rtl/store_wr_buf.sv
// Store write buffer: queues lane-aligned stores, merges into the youngest
// entry, presents the head to memory, flags load hazards and drains on fence.
module store_wr_buf
  import store_wr_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iPushVld,
  output logic                   oPushRdy,
  input  logic [31:0]            iPushAddr,
  input  logic [31:0]            iPushMask,
  input  logic [31:0]            iPushDat,
  output logic                   oMemVld,
  input  logic                   iMemRdy,
  output logic [31:0]            oMemAddr,
  output logic [31:0]            oMemMask,
  output logic [31:0]            oMemDat,
  input  logic [31:0]            iLdAddr,
  output logic                   oLdHit,
  input  logic                   iDrainReq,
  output logic                   oDrainDone,
  output logic [$clog2(DEPTH):0] oCnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] w_head;
  logic [PW-1:0] w_tail;
  logic [PW-1:0] w_young;
  logic [CW-1:0] w_cnt;
  logic [PW-1:0] w_off;
  logic          w_full;
  logic          w_merge_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_do_alloc;
  logic          w_do_merge;
  logic          w_unused;
  entry_t        w_head_ent;
  entry_t        w_young_ent;

  entry_t        r_mem [DEPTH];

  drain_state_e  r_state;
  drain_state_e  w_state_nxt;

  store_wr_buf_ptr #(.DEPTH(DEPTH)) u_ptr (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .i_alloc    (w_do_alloc),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_tail     (w_tail),
    .o_youngest (w_young),
    .o_cnt      (w_cnt)
  );

  assign w_head_ent  = r_mem[w_head];
  assign w_young_ent = r_mem[w_young];

  assign w_full     = (w_cnt == CW'(DEPTH));
  assign w_merge_ok = (w_cnt >= CW'(2)) && (iPushAddr[31:2] == w_young_ent.addr);
  assign oPushRdy   = (r_state == ST_IDLE) && (!w_full || w_merge_ok);
  assign w_push     = iPushVld && oPushRdy;
  // An all-zero mask is accepted but writes nothing, so it never allocates.
  assign w_do_merge = w_push && (|iPushMask) && w_merge_ok;
  assign w_do_alloc = w_push && (|iPushMask) && !w_merge_ok;

  assign oMemVld  = (w_cnt != '0);
  assign w_pop    = oMemVld && iMemRdy;
  assign oMemAddr = {w_head_ent.addr, 2'b00};
  assign oMemMask = w_head_ent.mask;
  assign oMemDat  = w_head_ent.dat;
  assign oCnt     = w_cnt;

  // NOTE: entry storage has no reset; validity is carried by the pointers and
  // count alone, which keeps the array a plain memory.
  always_ff @(posedge iClk) begin
    if (w_do_alloc) begin
      r_mem[w_tail] <= '{addr: iPushAddr[31:2], mask: iPushMask, dat: iPushDat};
    end else if (w_do_merge) begin
      r_mem[w_young] <= '{addr: w_young_ent.addr,
                          mask: w_young_ent.mask | iPushMask,
                          dat:  merge_bits(w_young_ent.dat, iPushDat, iPushMask)};
    end
  end

  // Entry i is valid when its distance from head is below the count.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    oLdHit = 1'b0;
    w_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - w_head;
      if (({1'b0, w_off} < w_cnt) && (r_mem[i].addr == iLdAddr[31:2])) begin
        oLdHit = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    oDrainDone  = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (iDrainReq) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE: begin
        oDrainDone  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_unused = ^{iPushAddr[1:0], iLdAddr[1:0]};

endmodule
